// File: rtl/ahb_rf_slave_ctrl.sv
// AHB-Lite slave front end for a word-addressed register file.
// Decodes AHB address phases into register-file read/write strobes and
// inserts a fixed number of wait states. Illegal accesses get the
// standard two-cycle ERROR response and never reach the register file.
//
// Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY and the
// block is not stalling its own data phase (IDLE, ACCESS, ERR2). A data phase
// completes on the cycle HREADYOUT=1. HREADY is only ever sampled for
// acceptance; while HREADYOUT=0 all bus inputs are ignored.
module ahb_rf_slave_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 16,
  parameter int WAIT_STATES    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  rf_rd_en,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_e;

  // Counter reload value; only meaningful when wait states are configured.
  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_e                state_q, state_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  write_q, write_d;

  logic                  accept;
  logic                  illegal;
  logic                  open_phase;
  logic [ADDR_WIDTH-1:0] idx_in;

  assign idx_in  = {2'b00, HADDR[ADDR_WIDTH-1:2]};
  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign illegal = (idx_in >= ADDR_WIDTH'(REG_FILE_DEPTH)) |
                   (HADDR[1:0] != 2'b00) |
                   (HSIZE != 3'b010);

  // State, wait counter and registered address/control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 2'd0;
      idx_q      <= '0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
    end
  end

  // Next state: finish the current data phase, then possibly take a new address phase.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    open_phase = 1'b0;
    case (state_q)
      S_IDLE, S_ACCESS, S_ERR2: begin
        state_d    = S_IDLE;
        open_phase = 1'b1;
      end
      S_WAIT: begin
        if (wait_cnt_q == 2'd0) state_d = S_ACCESS;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (open_phase && accept) begin
      idx_d   = idx_in;
      write_d = HWRITE;
      if (illegal) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d    = S_WAIT;
        wait_cnt_d = WAIT_LOAD;
      end else begin
        state_d = S_ACCESS;
      end
    end
  end

  // Bus response and register-file strobes decoded from the current state only.
  always_comb begin
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = '0;
    rf_rd_en   = 1'b0;
    rf_wr_en   = 1'b0;
    rf_address = '0;
    rf_wr_data = '0;
    case (state_q)
      S_WAIT: begin
        HREADYOUT  = 1'b0;
        rf_rd_en   = ~write_q;
        rf_address = idx_q;
      end
      S_ACCESS: begin
        rf_address = idx_q;
        if (write_q) begin
          rf_wr_en   = 1'b1;
          rf_wr_data = HWDATA;
        end else begin
          rf_rd_en = 1'b1;
          HRDATA   = rf_rd_data;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_rf_slave_ctrl.sv
// Bench for ahb_rf_slave_ctrl: three instances (0, 2 and 3 wait states) share
// one stimulus stream; each has its own HREADY loop-back and register file.
module tb_ahb_rf_slave_ctrl;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_gate;

  // ---------------- per-instance signals ----------------
  logic        hready_in [3];
  logic [31:0] hrdata    [3];
  logic        hreadyout [3];
  logic        hresp     [3];
  logic        rf_rd_en  [3];
  logic        rf_wr_en  [3];
  logic [31:0] rf_address[3];
  logic [31:0] rf_wr_data[3];
  logic [31:0] rf_rd_data[3];
  logic [2:0]  dbg_state [3];

  ahb_rf_slave_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_FILE_DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_in[0]), .HRDATA(hrdata[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .rf_rd_en(rf_rd_en[0]), .rf_wr_en(rf_wr_en[0]),
    .rf_address(rf_address[0]), .rf_wr_data(rf_wr_data[0]), .rf_rd_data(rf_rd_data[0]),
    .dbg_state(dbg_state[0]));

  ahb_rf_slave_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_FILE_DEPTH(16), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_in[1]), .HRDATA(hrdata[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .rf_rd_en(rf_rd_en[1]), .rf_wr_en(rf_wr_en[1]),
    .rf_address(rf_address[1]), .rf_wr_data(rf_wr_data[1]), .rf_rd_data(rf_rd_data[1]),
    .dbg_state(dbg_state[1]));

  ahb_rf_slave_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_FILE_DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_in[2]), .HRDATA(hrdata[2]),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .rf_rd_en(rf_rd_en[2]), .rf_wr_en(rf_wr_en[2]),
    .rf_address(rf_address[2]), .rf_wr_data(rf_wr_data[2]), .rf_rd_data(rf_rd_data[2]),
    .dbg_state(dbg_state[2]));

  // Each slave is the only one on its bus, so HREADY is its own HREADYOUT,
  // optionally pulled low to mimic another slave stalling.
  assign hready_in[0] = hreadyout[0] & hready_gate;
  assign hready_in[1] = hreadyout[1] & hready_gate;
  assign hready_in[2] = hreadyout[2] & hready_gate;

  // ---------------- environment register files ----------------
  logic [31:0] env_mem [3][16];
  logic        env_ready = 1'b0;

  assign rf_rd_data[0] = env_mem[0][rf_address[0][3:0]];
  assign rf_rd_data[1] = env_mem[1][rf_address[1][3:0]];
  assign rf_rd_data[2] = env_mem[2][rf_address[2][3:0]];

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 16; i++)
          env_mem[k][i] = 32'hA500_0000 | 32'(i);
      env_ready = 1'b1;
    end
    for (int k = 0; k < 3; k++)
      if (rf_wr_en[k]) env_mem[k][rf_address[k][3:0]] = rf_wr_data[k];
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slave holds at most one outstanding data phase: legal ones stall for
  // the configured wait count then complete, illegal ones stall one cycle with
  // ERROR then complete with ERROR. The model memory commits a write when its
  // data phase completes.
  function automatic int ws_of(input int m);
    return (m == 0) ? 0 : ((m == 1) ? 2 : 3);
  endfunction

  logic        dp_v    [3];
  logic        dp_err  [3];
  logic        dp_wr   [3];
  logic [31:0] dp_idx  [3];
  int          dp_stall[3];
  logic [31:0] mem_m   [3][16];
  logic        model_ready = 1'b0;

  always @(negedge clk) begin
    logic        e_ready, e_resp, e_rd, e_wr;
    logic [31:0] e_addr, e_wdata, e_rdata, a_idx;
    logic        a_err;
    logic [127:0] act_v, exp_v;
    if (!model_ready) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 16; i++) mem_m[k][i] = 32'hA500_0000 | 32'(i);
        dp_v[k] = 1'b0; dp_err[k] = 1'b0; dp_wr[k] = 1'b0; dp_idx[k] = '0; dp_stall[k] = 0;
      end
      model_ready = 1'b1;
    end
    for (int m = 0; m < 3; m++) begin
      e_ready = 1'b1; e_resp = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
      if (!rst) begin
        dp_v[m] = 1'b0;
      end else if (dp_v[m]) begin
        e_ready = (dp_stall[m] == 0);
        if (dp_err[m]) begin
          e_resp = 1'b1;
        end else begin
          e_addr = dp_idx[m];
          e_rd   = !dp_wr[m];
          if (dp_stall[m] == 0) begin
            if (dp_wr[m]) begin e_wr = 1'b1; e_wdata = hwdata; end
            else           e_rdata = mem_m[m][dp_idx[m][3:0]];
          end
        end
      end
      act_v = {28'd0, hreadyout[m], hresp[m], rf_rd_en[m], rf_wr_en[m], rf_address[m], rf_wr_data[m], hrdata[m]};
      exp_v = {28'd0, e_ready, e_resp, e_rd, e_wr, e_addr, e_wdata, e_rdata};
      check($sformatf("model_u%0d", m), act_v, exp_v);
      // advance across the coming rising edge
      if (rst) begin
        if (dp_v[m] && dp_stall[m] > 0) begin
          dp_stall[m]--;
        end else begin
          if (dp_v[m] && !dp_err[m] && dp_wr[m]) mem_m[m][dp_idx[m][3:0]] = hwdata;
          dp_v[m] = 1'b0;
          if (hsel && htrans[1] && e_ready && hready_gate) begin
            a_idx = haddr >> 2;
            a_err = (a_idx >= 32'd16) || (haddr[1:0] != 2'b00) || (hsize != 3'b010);
            dp_v[m]     = 1'b1;
            dp_err[m]   = a_err;
            dp_wr[m]    = hwrite;
            dp_idx[m]   = a_idx;
            dp_stall[m] = a_err ? 1 : ws_of(m);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic g);
    @(posedge clk); #1;
    hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz; hwdata = wd; hready_gate = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
  endtask

  task automatic drive_rand();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 19);
    if (r == 0)     a = $urandom;
    else if (r < 3) a = 32'($urandom_range(0, 'h4F));
    else            a = 32'($urandom_range(0, 17)) << 2;
    drive(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
          ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010,
          $urandom, ($urandom_range(0, 7) != 0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lo_cnt, rd_cnt;
    logic [31:0] rd_val;
    rst = 1'b0;
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = '0; hsize = 3'b010; hwdata = '0;
    hready_gate = 1'b1;
    @(negedge clk);
    check("reset_u0", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'h8);
    check("reset_state_u2", {125'd0, dbg_state[1]}, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // write 0x08 then pipelined read of 0x08 with no wait states
    drive(1'b1, T_NONSEQ, 1'b1, 32'h08, 3'b010, 32'd0, 1'b1);
    drive(1'b1, T_NONSEQ, 1'b0, 32'h08, 3'b010, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("ws0_write", {62'd0, hreadyout[0], rf_wr_en[0], rf_address[0], rf_wr_data[0]},
          {62'd0, 1'b1, 1'b1, 32'd2, 32'hDEADBEEF});
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
    @(negedge clk);
    check("ws0_readback", {93'd0, hreadyout[0], hresp[0], rf_rd_en[0], hrdata[0]},
          {93'd0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
    idle(6);

    // read 0x3C with two wait states
    drive(1'b1, T_NONSEQ, 1'b0, 32'h3C, 3'b010, 32'd0, 1'b1);
    lo_cnt = 0; rd_cnt = 0; rd_val = '0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
      @(negedge clk);
      if (!hreadyout[1]) lo_cnt++;
      if (rf_rd_en[1]) rd_cnt++;
      if (rf_rd_en[1] && hreadyout[1]) rd_val = hrdata[1];
    end
    check("ws2_low_cycles", 128'(lo_cnt), 128'd2);
    check("ws2_rd_en_cycles", 128'(rd_cnt), 128'd3);
    check("ws2_rdata", {96'd0, rd_val}, {96'd0, 32'hA500_000F});
    idle(2);

    // out-of-range read 0x40
    drive(1'b1, T_NONSEQ, 1'b0, 32'h40, 3'b010, 32'd0, 1'b1);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
    @(negedge clk);
    check("oor_err1", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'h4);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
    @(negedge clk);
    check("oor_err2", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'hC);
    idle(2);

    // unaligned write, then byte-size write presented during ERR2
    drive(1'b1, T_NONSEQ, 1'b1, 32'h06, 3'b010, 32'd0, 1'b1);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'h1111_1111, 1'b1);
    @(negedge clk);
    check("unal_err1", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'h4);
    drive(1'b1, T_NONSEQ, 1'b1, 32'h08, 3'b000, 32'h2222_2222, 1'b1);
    @(negedge clk);
    check("unal_err2", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'hC);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'h3333_3333, 1'b1);
    @(negedge clk);
    check("byte_err1", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'h4);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'd0, 1'b1);
    @(negedge clk);
    check("byte_err2", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'hC);
    idle(4);
    check("rf_idx1_kept", {96'd0, env_mem[0][1]}, {96'd0, 32'hA500_0001});
    check("rf_idx2_kept", {96'd0, env_mem[0][2]}, {96'd0, 32'hDEADBEEF});

    // BUSY transfer and NONSEQ while HREADY is low
    drive(1'b1, T_BUSY, 1'b1, 32'h0C, 3'b010, 32'd0, 1'b1);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'h4444_4444, 1'b1);
    @(negedge clk);
    check("busy_okay", {124'd0, hreadyout[0], hresp[0], rf_rd_en[0], rf_wr_en[0]}, 128'h8);
    drive(1'b1, T_NONSEQ, 1'b1, 32'h0C, 3'b010, 32'd0, 1'b0);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'h5555_5555, 1'b1);
    @(negedge clk);
    check("hready_low_okay", {124'd0, hreadyout[2], hresp[2], rf_rd_en[2], rf_wr_en[2]}, 128'h8);
    idle(2);

    // reset during WAIT of a 3-wait-state write to 0x04
    drive(1'b1, T_NONSEQ, 1'b1, 32'h04, 3'b010, 32'd0, 1'b1);
    drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'b010, 32'h1234_5678, 1'b1);
    @(negedge clk);
    check("ws3_in_wait", {127'd0, hreadyout[2]}, 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ws3_reset_now", {89'd0, hreadyout[2], hresp[2], rf_rd_en[2], rf_wr_en[2], rf_address[2], dbg_state[2]},
          {89'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0});
    @(posedge clk); #1 rst = 1'b1;
    idle(6);
    check("ws3_idx1_kept", {96'd0, env_mem[2][1]}, {96'd0, 32'hA500_0001});

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) drive_rand();
    idle(8);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
